// File: rtl/screen_driver.sv
// SSD1306 SPI master: panel power sequencing, fixed init command list, then endless
// frame-buffer streaming (1024 bytes per frame, addresses fetched from a synchronous source).
module screen_driver #(
    parameter logic [23:0] STARTUP_WAIT = 24'd10000000,
    parameter logic [7:0]  CLK_DIV      = 8'd2
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [9:0] pixelAddress,
    input  logic [7:0] pixelData,
    output logic       io_sclk,
    output logic       io_sdin,
    output logic       io_cs,
    output logic       io_dc,
    output logic       io_reset,
    output logic       frameDone
);

    typedef enum logic [2:0] {
        PWR_HI1, PWR_LO, PWR_HI2, CMD_LOAD, SHIFT, DATA_FETCH, DATA_LATCH
    } state_t;

    localparam logic [4:0] LAST_CMD = 5'd24;

    state_t      state_q, state_d;
    logic [23:0] wait_q, wait_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [4:0]  cmd_q, cmd_d;
    logic [7:0]  sr_q, sr_d;
    logic [9:0]  addr_q, addr_d;
    logic        sclk_q, sclk_d;
    logic        dc_q, dc_d;
    logic        rst_q, rst_d;
    logic        cs_q, cs_d;
    logic        done_q, done_d;

    logic wait_done, half_done, byte_done;

    function automatic logic [7:0] cmd_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  cmd_rom = 8'hAE;  5'd1:  cmd_rom = 8'hD5;  5'd2:  cmd_rom = 8'h80;
            5'd3:  cmd_rom = 8'hA8;  5'd4:  cmd_rom = 8'h3F;  5'd5:  cmd_rom = 8'hD3;
            5'd6:  cmd_rom = 8'h00;  5'd7:  cmd_rom = 8'h40;  5'd8:  cmd_rom = 8'h8D;
            5'd9:  cmd_rom = 8'h14;  5'd10: cmd_rom = 8'h20;  5'd11: cmd_rom = 8'h00;
            5'd12: cmd_rom = 8'hA1;  5'd13: cmd_rom = 8'hC8;  5'd14: cmd_rom = 8'hDA;
            5'd15: cmd_rom = 8'h12;  5'd16: cmd_rom = 8'h81;  5'd17: cmd_rom = 8'hCF;
            5'd18: cmd_rom = 8'hD9;  5'd19: cmd_rom = 8'hF1;  5'd20: cmd_rom = 8'hDB;
            5'd21: cmd_rom = 8'h40;  5'd22: cmd_rom = 8'hA4;  5'd23: cmd_rom = 8'hA6;
            5'd24: cmd_rom = 8'hAF;
            default: cmd_rom = 8'h00;
        endcase
    endfunction

    assign wait_done = (wait_q == STARTUP_WAIT - 24'd1);
    assign half_done = (div_q == CLK_DIV - 8'd1);
    assign byte_done = half_done && sclk_q && (bit_q == 3'd7);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= PWR_HI1;
            wait_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            sr_q    <= '0;
            addr_q  <= '0;
            sclk_q  <= 1'b0;
            dc_q    <= 1'b0;
            rst_q   <= 1'b1;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            sclk_q  <= sclk_d;
            dc_q    <= dc_d;
            rst_q   <= rst_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PWR_HI1:    if (wait_done) state_d = PWR_LO;
            PWR_LO:     if (wait_done) state_d = PWR_HI2;
            PWR_HI2:    if (wait_done) state_d = CMD_LOAD;
            CMD_LOAD:   state_d = SHIFT;
            SHIFT:
                if (byte_done)
                    state_d = (dc_q || cmd_q == LAST_CMD) ? DATA_FETCH : CMD_LOAD;
            DATA_FETCH: state_d = DATA_LATCH;
            DATA_LATCH: state_d = SHIFT;
            default:    state_d = PWR_HI1;
        endcase
    end

    always_comb begin
        wait_d = '0;
        div_d  = div_q;
        bit_d  = bit_q;
        cmd_d  = cmd_q;
        sr_d   = sr_q;
        addr_d = addr_q;
        sclk_d = sclk_q;
        dc_d   = dc_q;
        done_d = 1'b0;
        case (state_q)
            PWR_HI1, PWR_LO, PWR_HI2: wait_d = wait_done ? 24'd0 : wait_q + 24'd1;
            CMD_LOAD: begin
                sr_d   = cmd_rom(cmd_q);
                dc_d   = 1'b0;
                div_d  = '0;
                bit_d  = '0;
                sclk_d = 1'b0;
            end
            DATA_LATCH: begin
                sr_d   = pixelData;
                dc_d   = 1'b1;
                div_d  = '0;
                bit_d  = '0;
                sclk_d = 1'b0;
            end
            SHIFT: begin
                if (half_done) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    // Data advances only after the high half, so SDIN is stable across the rise.
                    if (sclk_q) begin
                        sr_d  = {sr_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
                if (byte_done) begin
                    if (dc_q) begin
                        addr_d = addr_q + 10'd1;
                        done_d = (addr_q == 10'd1023);
                    end else if (cmd_q != LAST_CMD) begin
                        cmd_d = cmd_q + 5'd1;
                    end
                end
            end
            default: ;
        endcase
        rst_d = (state_d != PWR_LO);
        cs_d  = (state_d == PWR_HI1) || (state_d == PWR_LO) || (state_d == PWR_HI2);
    end

    assign pixelAddress = addr_q;
    assign io_sclk      = sclk_q;
    assign io_sdin      = sr_q[7];
    assign io_cs        = cs_q;
    assign io_dc        = dc_q;
    assign io_reset     = rst_q;
    assign frameDone    = done_q;

endmodule

// File: tb/tb_screen_driver.sv
// Directed bench for screen_driver: reset values, power sequence, command list,
// two frames of streamed data against a synchronous memory model, and a mid-byte reset.
module tb_screen_driver;

    localparam logic [23:0] SW = 24'd4;
    localparam logic [7:0]  CD = 8'd2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] pixelAddress;
    logic [7:0] pixelData = 8'h00;
    logic       io_sclk, io_sdin, io_cs, io_dc, io_reset, frameDone;

    int checks = 0, failures = 0;
    int cyc = 0, fd_count = 0, fd_last = 0;

    logic [7:0] cmds [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                              8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                              8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

    screen_driver #(.STARTUP_WAIT(SW), .CLK_DIV(CD)) dut (
        .clk(clk), .resetn(resetn), .pixelAddress(pixelAddress), .pixelData(pixelData),
        .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc),
        .io_reset(io_reset), .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [9:0] a);
        return a[7:0] ^ {6'b0, a[9:8]};
    endfunction

    // cyc = number of rising edges since reset release, as seen between edges
    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
        pixelData <= mem(pixelAddress);
    end

    always @(negedge clk) begin
        if (resetn && frameDone) begin
            fd_count = fd_count + 1;
            fd_last  = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic abort(input string why);
        failures++;
        checks++;
        $display("FAIL %s timed out", why);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    endtask

    // Captures one byte at SCLK rises; bad counts period/DC irregularities inside the byte.
    task automatic get_byte(output logic [7:0] b, output logic dcv, output int t0,
                            output logic [9:0] adr, output int bad);
        int   n;
        int   tlast;
        logic prev;
        n = 0; tlast = 0; b = '0; dcv = 1'b0; t0 = -1; adr = '0; bad = 0;
        prev = io_sclk;
        for (int i = 0; i < 400 && n < 8; i++) begin
            @(negedge clk);
            if (io_sclk && !prev) begin
                if (n == 0) begin
                    t0 = cyc; dcv = io_dc; adr = pixelAddress;
                end else begin
                    if (cyc - tlast != 2 * int'(CD)) bad++;
                    if (io_dc !== dcv) bad++;
                end
                tlast = cyc;
                b = {b[6:0], io_sdin};
                n++;
            end
            prev = io_sclk;
        end
        if (n < 8) abort("get_byte");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sclk"}, 32'(io_sclk), 32'd0);
        chk({tag, "_sdin"}, 32'(io_sdin), 32'd0);
        chk({tag, "_cs"},   32'(io_cs), 32'd1);
        chk({tag, "_dc"},   32'(io_dc), 32'd0);
        chk({tag, "_rst"},  32'(io_reset), 32'd1);
        chk({tag, "_addr"}, 32'(pixelAddress), 32'd0);
        chk({tag, "_fd"},   32'(frameDone), 32'd0);
    endtask

    // Called right after resetn is raised at a falling edge.
    task automatic power_seq(input string tag);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            chk({tag, "_cyc"},   32'(cyc), 32'(c));
            chk({tag, "_reset"}, 32'(io_reset), (c >= 4 && c <= 7) ? 32'd0 : 32'd1);
            chk({tag, "_cs"},    32'(io_cs), (c >= 12) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       dcv;
        logic [9:0] adr;
        logic       prev;
        int         t0, bad, g, r;

        resetn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst");
        end

        resetn = 1'b1;
        power_seq("pwr");

        // First command rises at cycle 15, each command byte 33 cycles apart
        for (int k = 0; k < 25; k++) begin
            get_byte(b, dcv, t0, adr, bad);
            chk("cmd_byte", 32'(b), 32'(cmds[k]));
            chk("cmd_dc", 32'(dcv), 32'd0);
            chk("cmd_time", 32'(t0), 32'(15 + 33 * k));
            chk("cmd_bits", 32'(bad), 32'd0);
        end

        // Data byte g (global) first rise at 841 + 34*g; frame 1 then 500 bytes of frame 2
        for (g = 0; g < 1024 + 500; g++) begin
            get_byte(b, dcv, t0, adr, bad);
            chk("data_byte", 32'(b), 32'(mem(10'(g))));
            chk("data_addr", 32'(adr), 32'(g % 1024));
            chk("data_dc", 32'(dcv), 32'd1);
            chk("data_time", 32'(t0), 32'(841 + 34 * g));
            chk("data_bits", 32'(bad), 32'd0);
            if (g == 1024) begin
                chk("frame_done_count", 32'(fd_count), 32'd1);
                chk("frame_done_cycle", 32'(fd_last), 32'd35653);
            end
        end

        // Reset during the 4th bit (high phase) of byte 500 of frame 2
        r = 0;
        prev = io_sclk;
        for (int i = 0; i < 200 && r < 4; i++) begin
            @(negedge clk);
            if (io_sclk && !prev) r++;
            prev = io_sclk;
        end
        if (r < 4) abort("mid_byte_bits");
        chk("mid_addr", 32'(pixelAddress), 32'd500);
        chk("mid_sclk_high", 32'(io_sclk), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        resetn = 1'b1;
        power_seq("pwr2");
        get_byte(b, dcv, t0, adr, bad);
        chk("re_cmd_byte", 32'(b), 32'h0000_00AE);
        chk("re_cmd_dc", 32'(dcv), 32'd0);
        chk("re_cmd_time", 32'(t0), 32'd15);
        chk("re_cmd_bits", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
